// File: rtl/ad9361_ensm_pkg.sv
// ad9361_ensm_pkg: ENSM state encoding and counter load helper.
package ad9361_ensm_pkg;

    typedef enum logic [1:0] {
        ALERT  = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        TURN   = 2'd3
    } ensm_state_e;

    // Callers cast the result to their counter width.
    function automatic logic [31:0] cnt_load(input int val);
        return 32'(val - 1);
    endfunction

endpackage

// File: rtl/ad9361_ensm_sequencer_counter.sv
// ensm_guard_counter: loadable down-counter saturating at zero, with zero flag.
module ensm_guard_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= load_i ? val_i : (zero_o ? cnt_q : cnt_q - 1'b1);
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/ad9361_ensm_sequencer.sv
// ad9361_ensm_sequencer: AD9361 ENSM enable/txnrx sequencer with guard and turnaround timing.
// ENSM_TDD_SYNC_EN: gate leaving ALERT, TURN->SETUP and leaving ACTIVE on tdd_sync_i.
module ad9361_ensm_sequencer
    import ad9361_ensm_pkg::*;
#(
    parameter int PULSE_MODE   = 0,
    parameter int GUARD_CYCLES = 4,
    parameter int TURN_CYCLES  = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic       aclk,
    input  logic       arst,
    input  logic       up_enable,
    input  logic       up_txnrx,
    input  logic       tdd_sync_i,
    output logic       enable,
    output logic       txnrx,
    output logic       rx_on,
    output logic       tx_on,
    output logic       busy,
    output logic [1:0] state
);

    localparam logic [1:0] S_ALERT  = 2'(ALERT);
    localparam logic [1:0] S_SETUP  = 2'(SETUP);
    localparam logic [1:0] S_ACTIVE = 2'(ACTIVE);
    localparam logic [1:0] S_TURN   = 2'(TURN);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(cnt_load(GUARD_CYCLES));
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(cnt_load(TURN_CYCLES));
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(cnt_load(PULSE_CYCLES));

    logic [1:0] state_q, state_d;
    logic req_en_q, req_dir_q, enable_q, enable_d, txnrx_q, txnrx_d;
    logic rx_on_q, rx_on_d, tx_on_q, tx_on_d, exit_q, exit_d;
    logic ld, zero, change, sync;
    logic [CNT_W-1:0] ld_val;

`ifdef ENSM_TDD_SYNC_EN
    assign sync = tdd_sync_i;
`else
    logic sync_unused;
    assign sync        = 1'b1;
    assign sync_unused = tdd_sync_i;
`endif

    assign change = !req_en_q || req_dir_q != txnrx_q;

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        txnrx_d  = txnrx_q;
        rx_on_d  = rx_on_q;
        tx_on_d  = tx_on_q;
        exit_d   = exit_q;
        ld       = 1'b0;
        ld_val   = '0;
        case (state_q)
            S_ALERT: if (req_en_q && sync) begin
                state_d = S_SETUP;
                txnrx_d = req_dir_q;
                ld      = 1'b1;
                ld_val  = GUARD_LD;
            end
            S_SETUP: if (!req_en_q) begin
                state_d = S_ALERT;
            end else if (req_dir_q != txnrx_q) begin
                txnrx_d = req_dir_q;
                ld      = 1'b1;
                ld_val  = GUARD_LD;
            end else if (zero) begin
                state_d  = S_ACTIVE;
                enable_d = 1'b1;
                rx_on_d  = !txnrx_q;
                tx_on_d  = txnrx_q;
                ld       = PULSE_MODE != 0;
                ld_val   = PULSE_LD;
            end
            S_ACTIVE: if (PULSE_MODE == 0) begin
                if (change && sync) begin
                    state_d  = S_TURN;
                    enable_d = 1'b0;
                    rx_on_d  = 1'b0;
                    tx_on_d  = 1'b0;
                    ld       = 1'b1;
                    ld_val   = TURN_LD;
                end
            end else if (exit_q) begin
                if (zero) begin
                    state_d  = S_TURN;
                    enable_d = 1'b0;
                    exit_d   = 1'b0;
                    ld       = 1'b1;
                    ld_val   = TURN_LD;
                end
            end else if (enable_q) begin
                enable_d = !zero;
            end else if (change && sync) begin
                // exit pulse: direction flags drop as it starts
                enable_d = 1'b1;
                exit_d   = 1'b1;
                rx_on_d  = 1'b0;
                tx_on_d  = 1'b0;
                ld       = 1'b1;
                ld_val   = PULSE_LD;
            end
            S_TURN: if (zero) begin
                if (!req_en_q) begin
                    state_d = S_ALERT;
                end else if (sync) begin
                    state_d = S_SETUP;
                    txnrx_d = req_dir_q;
                    ld      = 1'b1;
                    ld_val  = GUARD_LD;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q   <= S_ALERT;
            req_en_q  <= 1'b0;
            req_dir_q <= 1'b0;
            enable_q  <= 1'b0;
            txnrx_q   <= 1'b0;
            rx_on_q   <= 1'b0;
            tx_on_q   <= 1'b0;
            exit_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_en_q  <= up_enable;
            req_dir_q <= up_txnrx;
            enable_q  <= enable_d;
            txnrx_q   <= txnrx_d;
            rx_on_q   <= rx_on_d;
            tx_on_q   <= tx_on_d;
            exit_q    <= exit_d;
        end
    end

    ensm_guard_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (aclk),
        .rst    (arst),
        .load_i (ld),
        .val_i  (ld_val),
        .zero_o (zero)
    );

    assign enable = enable_q;
    assign txnrx  = txnrx_q;
    assign rx_on  = rx_on_q;
    assign tx_on  = tx_on_q;
    assign busy   = state_q == S_SETUP || state_q == S_TURN;
    assign state  = state_q;

endmodule
